seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
Parametrised, clocked successor to the team's combinational 4-bit ALU, for use behind the lab's FPGA register file and 7-segment front end.
- Registers operands and opcode on a start/ready handshake.
- Executes simple ops in one cycle; MUL runs as an iterative shift-add and DIV/MOD as an iterative restoring divider.
- Returns a registered result, a high result word and status flags with a one-cycle done pulse.
- Replaces the combinational `*`, `/` and `%` operators, so the block synthesises small at any width.

Parameters:
W, 4, operand/result width in bits (W >= 2).
CW, $clog2(W+1), iteration counter width (derived, not overridden).

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
start  in  1  request; accepted only when ready=1.
a  in  W  operand A (unsigned, two's complement for V/N).
b  in  W  operand B.
op  in  4  opcode: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 MOD, 5 AND, 6 OR, 7 XOR, 8 SHL, 9 SHR; 10-15 illegal.
ready  out  1  high in IDLE; can accept start.
done  out  1  one-cycle pulse; result/flags valid from this cycle.
result  out  W  low result word.
result_hi  out  W  MUL high word; DIV remainder; 0 otherwise.
flag_n  out  1  result[W-1].
flag_z  out  1  result == 0.
flag_c  out  1  carry/borrow/mul-overflow.
flag_v  out  1  signed overflow (ADD/SUB only).
flag_err  out  1  divide by zero or illegal opcode.

Behaviour:
Reset and handshake:
- Reset (async assert, sync release): state IDLE, ready=1, done=0; result, result_hi and all flags = 0; counter = 0.
- Acceptance edge: rising edge with start=1 and ready=1. At this edge a, b and op are latched and ready drops the next cycle.
- start while ready=0 is ignored; no queueing.
- Outputs hold until the next done. They do not change at acceptance.

FSM states: IDLE, EXEC, ITER, DONE.
- IDLE -> EXEC on acceptance.
- EXEC -> DONE for all ops other than MUL and DIV/MOD with b != 0. EXEC -> ITER for MUL, and for DIV/MOD with b != 0.
- ITER runs exactly W cycles, counted by the iteration counter, then goes to DONE.
- DONE: outputs are updated on entry; done=1 for exactly this cycle; next state IDLE, so ready=1 the following cycle.

Latency:
- done is high 2 cycles after the acceptance edge for single-cycle ops.
- done is high W+2 cycles after the acceptance edge for MUL/DIV/MOD.
- Back-to-back operation: a start asserted in the first ready cycle after DONE is accepted.

Operations:
- ADD: {flag_c, result} = a+b. flag_v = (a[W-1]==b[W-1]) & (result[W-1]!=a[W-1]).
- SUB: result = a-b mod 2^W. flag_c = 1 when a<b (unsigned borrow). flag_v = (a[W-1]^b[W-1]) & (a[W-1]^result[W-1]).
- MUL: unsigned; {result_hi, result} = a*b, 2W bits. Computed by shift-add, one partial product per ITER cycle. flag_c = |result_hi.
- DIV/MOD: unsigned restoring division, one quotient bit per ITER cycle.
  - DIV: result = quotient, result_hi = remainder.
  - MOD: result = remainder, result_hi = quotient.
- Divide by zero (b=0, DIV or MOD): no ITER. result = all ones, result_hi = a, flag_err=1, latency 2.
- AND/OR/XOR: bitwise.
- SHL/SHR: logical shifts by the unsigned value of b; b >= W gives 0. flag_c = last bit shifted out, or 0 when b=0 or b > W.
- Illegal op: result = 0, result_hi = 0, flag_err=1, latency 2.

Flags:
- flag_n and flag_z are always derived from result.
- flag_c is 0 except for ADD, SUB, MUL, SHL and SHR as stated above.
- flag_v is 0 except for ADD and SUB.
- flag_err is 0 except on divide by zero or an illegal op.

Reset and input timing:
- Reset during ITER or DONE aborts the operation. No done pulse follows; state is IDLE with reset values.
- Operand inputs may change freely after acceptance; the latched copies are used.

Test Plan:
- W=4, ADD a=7 b=9 -> 2 cycles after acceptance: done=1, result=0, flag_c=1, flag_z=1, flag_v=0. Then ADD a=7 b=1 -> result=8, flag_v=1, flag_n=1.
- W=4, SUB a=3 b=5 -> result=4'b1110, flag_c=1, flag_n=1, flag_v=0, latency 2.
- W=4, MUL a=13 b=11 -> done exactly 6 cycles after acceptance, result_hi=8, result=15, flag_c=1. Also check ready=0 throughout, and that a start pulse mid-operation is ignored (no second done).
- W=4, DIV a=13 b=4 -> result=3, result_hi=1. MOD same operands -> result=1, result_hi=3. DIV a=9 b=0 -> latency 2, result=15, result_hi=9, flag_err=1.
- W=8, SHL a=8'h81 b=1 -> result=8'h02, flag_c=1. SHR a=8'h81 b=9 -> result=0, flag_z=1. Illegal op=12 -> result=0, flag_err=1.
- Reset asserted mid-MUL (W=8, 3 cycles into ITER) -> outputs 0 asynchronously, ready=1 after release, no done. Then a back-to-back ADD issued the cycle ready returns completes normally.

Source files
------------

// File: rtl/seq_alu.sv
// Sequential ALU: latches operands on a start/ready handshake, runs simple ops in one
// cycle and MUL/DIV/MOD iteratively (shift-add, restoring divide), then pulses done.
module seq_alu #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [3:0]   op,
  output logic         ready,
  output logic         done,
  output logic [W-1:0] result,
  output logic [W-1:0] result_hi,
  output logic         flag_n,
  output logic         flag_z,
  output logic         flag_c,
  output logic         flag_v,
  output logic         flag_err
);
  localparam int CW = $clog2(W + 1);

  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_MUL = 4'd2, OP_DIV = 4'd3,
                         OP_MOD = 4'd4, OP_AND = 4'd5, OP_OR  = 4'd6, OP_XOR = 4'd7,
                         OP_SHL = 4'd8, OP_SHR = 4'd9;

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, ITER = 2'd2, DONE = 2'd3} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d;
  logic [3:0]    op_q, op_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  hi_q, hi_d, lo_q, lo_d;
  logic [W-1:0]  result_q, result_d, result_hi_q, result_hi_d;
  logic          flag_n_q, flag_n_d, flag_z_q, flag_z_d, flag_c_q, flag_c_d;
  logic          flag_v_q, flag_v_d, flag_err_q, flag_err_d;

  // Single-cycle results from the latched operands
  logic [W:0]    sum, diff, shl_ext, shr_ext;
  logic [W-1:0]  ex_res, ex_hi;
  logic          ex_c, ex_v, ex_err;

  always_comb begin
    sum     = {1'b0, a_q} + {1'b0, b_q};
    diff    = {1'b0, a_q} - {1'b0, b_q};
    shl_ext = {1'b0, a_q} << b_q;
    shr_ext = {a_q, 1'b0} >> b_q;
    ex_res  = '0;
    ex_hi   = '0;
    ex_c    = 1'b0;
    ex_v    = 1'b0;
    ex_err  = 1'b0;
    case (op_q)
      OP_ADD: begin
        ex_res = sum[W-1:0];
        ex_c   = sum[W];
        ex_v   = (a_q[W-1] == b_q[W-1]) & (sum[W-1] != a_q[W-1]);
      end
      OP_SUB: begin
        ex_res = diff[W-1:0];
        ex_c   = diff[W];
        ex_v   = (a_q[W-1] ^ b_q[W-1]) & (a_q[W-1] ^ diff[W-1]);
      end
      OP_DIV, OP_MOD: begin
        // Only reaches DONE from EXEC with b == 0
        ex_res = '1;
        ex_hi  = a_q;
        ex_err = 1'b1;
      end
      OP_MUL: ex_res = '0;
      OP_AND: ex_res = a_q & b_q;
      OP_OR:  ex_res = a_q | b_q;
      OP_XOR: ex_res = a_q ^ b_q;
      OP_SHL: begin
        ex_res = shl_ext[W-1:0];
        ex_c   = shl_ext[W];
      end
      OP_SHR: begin
        ex_res = shr_ext[W:1];
        ex_c   = shr_ext[0];
      end
      default: ex_err = 1'b1;
    endcase
  end

  // One iteration step: hi_q/lo_q hold {partial, multiplier} or {remainder, dividend/quotient}
  logic [W:0]    mul_sum, div_sh;
  logic [W-1:0]  mul_hi, mul_lo, div_hi, div_lo, div_rem;
  logic          div_ge;
  logic [W-1:0]  it_res, it_hi;
  logic          it_c;

  always_comb begin
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    mul_hi  = mul_sum[W:1];
    mul_lo  = {mul_sum[0], lo_q[W-1:1]};
    div_sh  = {hi_q, lo_q[W-1]};
    div_ge  = (div_sh >= {1'b0, b_q});
    div_rem = div_sh[W-1:0] - b_q;
    div_hi  = div_ge ? div_rem : div_sh[W-1:0];
    div_lo  = {lo_q[W-2:0], div_ge};
    it_c    = 1'b0;
    case (op_q)
      OP_MUL: begin
        it_res = mul_lo;
        it_hi  = mul_hi;
        it_c   = |mul_hi;
      end
      OP_DIV: begin
        it_res = div_lo;
        it_hi  = div_hi;
      end
      default: begin
        it_res = div_hi;
        it_hi  = div_lo;
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    flag_n_d    = flag_n_q;
    flag_z_d    = flag_z_q;
    flag_c_d    = flag_c_q;
    flag_v_d    = flag_v_q;
    flag_err_d  = flag_err_q;
    case (state_q)
      IDLE: if (start) begin
        a_d     = a;
        b_d     = b;
        op_d    = op;
        state_d = EXEC;
      end
      EXEC: begin
        cnt_d = '0;
        if ((op_q == OP_MUL) || (((op_q == OP_DIV) || (op_q == OP_MOD)) && (b_q != '0))) begin
          hi_d    = '0;
          lo_d    = a_q;
          state_d = ITER;
        end else begin
          result_d    = ex_res;
          result_hi_d = ex_hi;
          flag_n_d    = ex_res[W-1];
          flag_z_d    = (ex_res == '0);
          flag_c_d    = ex_c;
          flag_v_d    = ex_v;
          flag_err_d  = ex_err;
          state_d     = DONE;
        end
      end
      ITER: begin
        hi_d = (op_q == OP_MUL) ? mul_hi : div_hi;
        lo_d = (op_q == OP_MUL) ? mul_lo : div_lo;
        if (cnt_q == CW'(W - 1)) begin
          result_d    = it_res;
          result_hi_d = it_hi;
          flag_n_d    = it_res[W-1];
          flag_z_d    = (it_res == '0);
          flag_c_d    = it_c;
          flag_v_d    = 1'b0;
          flag_err_d  = 1'b0;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      cnt_q       <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      result_q    <= '0;
      result_hi_q <= '0;
      flag_n_q    <= 1'b0;
      flag_z_q    <= 1'b0;
      flag_c_q    <= 1'b0;
      flag_v_q    <= 1'b0;
      flag_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      flag_n_q    <= flag_n_d;
      flag_z_q    <= flag_z_d;
      flag_c_q    <= flag_c_d;
      flag_v_q    <= flag_v_d;
      flag_err_q  <= flag_err_d;
    end
  end

  assign ready     = (state_q == IDLE);
  assign done      = (state_q == DONE);
  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign flag_n    = flag_n_q;
  assign flag_z    = flag_z_q;
  assign flag_c    = flag_c_q;
  assign flag_v    = flag_v_q;
  assign flag_err  = flag_err_q;

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: W=4 and W=8 instances, directed cases plus random ops checked
// against an arithmetic reference model.
module tb_seq_alu;
  logic       clk = 1'b0;
  logic       rst;
  logic       start4, start8;
  logic [3:0] a4, b4, op4, op8;
  logic [7:0] a8, b8;

  logic       ready4, done4, n4, z4, c4, v4, e4;
  logic [3:0] res4, hi4;
  logic       ready8, done8, n8, z8, c8, v8, e8;
  logic [7:0] res8, hi8;

  int errors = 0;
  int checks = 0;
  logic sel;

  always #5 clk = ~clk;

  seq_alu #(.W(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .op(op4),
    .ready(ready4), .done(done4), .result(res4), .result_hi(hi4),
    .flag_n(n4), .flag_z(z4), .flag_c(c4), .flag_v(v4), .flag_err(e4)
  );

  seq_alu #(.W(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .op(op8),
    .ready(ready8), .done(done8), .result(res8), .result_hi(hi8),
    .flag_n(n8), .flag_z(z8), .flag_c(c8), .flag_v(v8), .flag_err(e8)
  );

  logic       o_ready, o_done, o_n, o_z, o_c, o_v, o_e;
  logic [7:0] o_res, o_hi;

  always_comb begin
    o_ready = sel ? ready8 : ready4;
    o_done  = sel ? done8  : done4;
    o_res   = sel ? res8   : {4'b0, res4};
    o_hi    = sel ? hi8    : {4'b0, hi4};
    o_n     = sel ? n8 : n4;
    o_z     = sel ? z8 : z4;
    o_c     = sel ? c8 : c4;
    o_v     = sel ? v8 : v4;
    o_e     = sel ? e8 : e4;
  end

  typedef struct {
    logic [7:0] r;
    logic [7:0] h;
    logic n, z, c, v, e;
    int lat;
  } exp_t;

  function automatic exp_t model(input int w, input logic [3:0] op,
                                 input logic [7:0] a, input logic [7:0] b);
    exp_t x;
    int unsigned ai, bi, mask, r, h;
    ai = a; bi = b; mask = (32'd1 << w) - 1;
    r = 0; h = 0;
    x.c = 0; x.v = 0; x.e = 0; x.lat = 2;
    case (op)
      0: begin
        r = (ai + bi) & mask;
        x.c = ((ai + bi) > mask);
        x.v = (((ai >> (w-1)) & 1) == ((bi >> (w-1)) & 1)) && (((r >> (w-1)) & 1) != ((ai >> (w-1)) & 1));
      end
      1: begin
        r = (ai - bi) & mask;
        x.c = (ai < bi);
        x.v = (((ai >> (w-1)) & 1) != ((bi >> (w-1)) & 1)) && (((r >> (w-1)) & 1) != ((ai >> (w-1)) & 1));
      end
      2: begin
        r = (ai * bi) & mask;
        h = (ai * bi) >> w;
        x.c = (h != 0);
        x.lat = w + 2;
      end
      3, 4: begin
        if (bi == 0) begin
          r = mask; h = ai; x.e = 1;
        end else begin
          r = (op == 3) ? ai / bi : ai % bi;
          h = (op == 3) ? ai % bi : ai / bi;
          x.lat = w + 2;
        end
      end
      5: r = ai & bi;
      6: r = ai | bi;
      7: r = ai ^ bi;
      8: begin
        r = (bi >= w) ? 0 : (ai << bi) & mask;
        x.c = (bi >= 1 && bi <= w) ? ((ai >> (w - bi)) & 1) : 0;
      end
      9: begin
        r = (bi >= w) ? 0 : ai >> bi;
        x.c = (bi >= 1 && bi <= w) ? ((ai >> (bi - 1)) & 1) : 0;
      end
      default: x.e = 1;
    endcase
    x.r = r[7:0];
    x.h = h[7:0];
    x.n = (r >> (w-1)) & 1;
    x.z = (r == 0);
    return x;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Entered and left at a negedge; the next call issues start in the first ready cycle.
  task automatic run_op(input logic s, input logic [3:0] op, input logic [7:0] a,
                        input logic [7:0] b, input bit inject, input string tag);
    exp_t x;
    logic [7:0] am, bm, prev;
    int n;
    logic rdy_bad;
    am = s ? a : {4'b0, a[3:0]};
    bm = s ? b : {4'b0, b[3:0]};
    x = model(s ? 8 : 4, op, am, bm);
    sel = s;
    #1;
    chk({tag, " ready_before"}, o_ready, 1);
    prev = o_res;
    if (s) begin a8 = am; b8 = bm; op8 = op; start8 = 1; end
    else begin a4 = am[3:0]; b4 = bm[3:0]; op4 = op; start4 = 1; end
    @(posedge clk);
    @(negedge clk);
    start4 = 0; start8 = 0;
    a4 = 4'($urandom); b4 = 4'($urandom); op4 = 4'($urandom);
    a8 = 8'($urandom); b8 = 8'($urandom); op8 = 4'($urandom);
    n = 1;
    chk({tag, " hold_at_accept"}, o_res, prev);
    rdy_bad = 0;
    while (!o_done && n < 40) begin
      if (o_ready) rdy_bad = 1;
      if (inject && n == 3) begin
        if (s) start8 = 1; else start4 = 1;
      end
      @(negedge clk);
      start4 = 0; start8 = 0;
      n++;
    end
    chk({tag, " latency"}, n, x.lat);
    chk({tag, " done"}, o_done, 1);
    chk({tag, " ready_low"}, rdy_bad, 0);
    chk({tag, " result"}, o_res, x.r);
    chk({tag, " result_hi"}, o_hi, x.h);
    chk({tag, " flags"}, {o_n, o_z, o_c, o_v, o_e}, {x.n, x.z, x.c, x.v, x.e});
    @(negedge clk);
    chk({tag, " done_pulse"}, {o_done, o_ready}, 2'b01);
  endtask

  initial begin
    rst = 1; sel = 0;
    start4 = 0; start8 = 0;
    a4 = 0; b4 = 0; op4 = 0; a8 = 0; b8 = 0; op8 = 0;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      chk("reset_outputs", {o_res, o_hi, o_n, o_z, o_c, o_v, o_e}, '0);
      chk("reset_hs", {o_ready, o_done}, 2'b10);
    end
    rst = 0;
    @(negedge clk);

    run_op(0, 4'd0, 8'd7, 8'd9, 0, "add_wrap");
    chk("add_wrap_const", {o_res, o_c, o_z, o_v}, {8'd0, 3'b110});
    run_op(0, 4'd0, 8'd7, 8'd1, 0, "add_ovf");
    chk("add_ovf_const", {o_res, o_v, o_n}, {8'd8, 2'b11});
    run_op(0, 4'd1, 8'd3, 8'd5, 0, "sub_borrow");
    chk("sub_const", {o_res, o_c, o_n, o_v}, {8'd14, 3'b110});
    run_op(0, 4'd2, 8'd13, 8'd11, 1, "mul4");
    chk("mul4_const", {o_hi, o_res, o_c}, {8'd8, 8'd15, 1'b1});
    for (int i = 0; i < 6; i++) begin
      chk("mul4_no_second_done", o_done, 0);
      @(negedge clk);
    end
    run_op(0, 4'd3, 8'd13, 8'd4, 0, "div4");
    chk("div4_const", {o_res, o_hi}, {8'd3, 8'd1});
    run_op(0, 4'd4, 8'd13, 8'd4, 0, "mod4");
    chk("mod4_const", {o_res, o_hi}, {8'd1, 8'd3});
    run_op(0, 4'd3, 8'd9, 8'd0, 0, "div0");
    chk("div0_const", {o_res, o_hi, o_e}, {8'd15, 8'd9, 1'b1});

    run_op(1, 4'd9, 8'h81, 8'd9, 0, "shr_big");
    chk("shr_big_const", {o_res, o_z}, {8'd0, 1'b1});
    run_op(1, 4'd12, 8'h55, 8'h33, 0, "illegal");
    chk("illegal_const", {o_res, o_e}, {8'd0, 1'b1});
    run_op(1, 4'd8, 8'h81, 8'd1, 0, "shl1");
    chk("shl1_const", {o_res, o_c}, {8'h02, 1'b1});

    // Abort a W=8 MUL three cycles into ITER
    sel = 1;
    a8 = 8'd200; b8 = 8'd150; op8 = 4'd2; start8 = 1;
    @(posedge clk);
    @(negedge clk);
    start8 = 0;
    repeat (3) @(negedge clk);
    rst = 1;
    #1;
    chk("abort_outputs", {o_res, o_hi, o_n, o_z, o_c, o_v, o_e}, '0);
    chk("abort_hs", {o_ready, o_done}, 2'b10);
    @(negedge clk);
    rst = 0;
    run_op(1, 4'd0, 8'd100, 8'd50, 0, "add_after_abort");

    for (int i = 0; i < 40; i++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom);
      rb = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom);
      run_op(1'($urandom), 4'($urandom_range(0, 11)), ra, rb, 0, $sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
